// File: rtl/hs_angle_dispatcher_pkg.sv
// rtl/hs_angle_dispatcher_pkg.sv - shared state encoding and PE bounds for the angle dispatcher
`ifndef kAngleLength
`define kAngleLength 16
`endif

package hs_angle_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_PE_MIN = 2;
  localparam int NUM_PE_MAX = 16;

endpackage

// File: rtl/hs_rr_pick.sv
// rtl/hs_rr_pick.sv - combinational round-robin picker: lowest free index at or after ptr, wrapping
module hs_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  free,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    any   = |free;
    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    for (int j = 0; j < N; j++) begin
      if (!found && free[j] && (j >= int'(ptr))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && free[j] && (j < int'(ptr))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_angle_dispatcher.sv
// rtl/hs_angle_dispatcher.sv - pulls angles from the host source and dispatches them round-robin to free PEs
// Optional angle counter enabled by defining HS_DISPATCH_COUNT_EN.
module hs_angle_dispatcher
  import hs_angle_dispatcher_pkg::*;
#(
  parameter int NUM_PE      = 4,
  parameter int ANGLE_WIDTH = `kAngleLength
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ANGLE_WIDTH-1:0] hs_angle,
  input  logic                   hs_has_next_angle,
  input  logic                   hs_next_angle_ack,
  output logic                   hs_next_angle,
  output logic [ANGLE_WIDTH-1:0] pe_angle,
  output logic [NUM_PE-1:0]      pe_load,
  input  logic [NUM_PE-1:0]      pe_done,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            angle_count
);

  localparam int PW = $clog2(NUM_PE);

  state_t                 state_q, state_d;
  logic [NUM_PE-1:0]      inflight_q, inflight_d;
  logic [NUM_PE-1:0]      pe_load_q, pe_load_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [ANGLE_WIDTH-1:0] pe_angle_q, pe_angle_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_PE-1:0]      grant;
  logic [PW-1:0]          grant_idx;
  logic                   any_free;
  logic                   consume;

  hs_rr_pick #(.N(NUM_PE), .PW(PW)) u_pick (
    .free  (~inflight_q),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any_free)
  );

  assign hs_next_angle = (state_q == ST_RUN) & hs_has_next_angle & any_free;
  assign consume       = hs_next_angle & hs_next_angle_ack;

  always_comb begin
    grant_idx = '0;
    for (int j = 0; j < NUM_PE; j++) begin
      if (grant[j]) grant_idx = PW'(j);
    end
  end

  always_comb begin
    state_d    = state_q;
    inflight_d = (inflight_q & ~pe_done) | (consume ? grant : '0);
    ptr_d      = ptr_q;
    pe_angle_d = pe_angle_q;
    pe_load_d  = '0;
    if (consume) begin
      pe_angle_d = hs_angle;
      pe_load_d  = grant;
      ptr_d      = (grant_idx == PW'(NUM_PE - 1)) ? '0 : grant_idx + 1'b1;
    end
    // Running out of source angles takes priority; a consume needs has_next anyway.
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (!hs_has_next_angle) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= '0;
      ptr_q      <= '0;
      pe_angle_q <= '0;
      pe_load_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      ptr_q      <= ptr_d;
      pe_angle_q <= pe_angle_d;
      pe_load_q  <= pe_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pe_angle = pe_angle_q;
  assign pe_load  = pe_load_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef HS_DISPATCH_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((state_q == ST_IDLE) && start) count_d = '0;
    else if (consume && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign angle_count = count_q;
`else
  assign angle_count = 16'd0;
`endif

endmodule
